// File: rtl/instruction_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// slave: encoder side; master: request producer and word consumer.
interface instruction_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        out_err;

  modport slave (
    input  in_valid, in_kind, in_rd, in_rs1,
    input  in_rs2, in_funct3, in_imm, out_ready,
    output in_ready, out_valid, out_instr,
    output out_last, out_err
  );

  modport master (
    output in_valid, in_kind, in_rd, in_rs1,
    output in_rs2, in_funct3, in_imm, out_ready,
    input  in_ready, out_valid, out_instr,
    input  out_last, out_err
  );
endinterface

// File: rtl/instruction_encoder.sv
// Packs kind/regs/immediate into RV32I words; LI expands to LUI+ADDI.
// Ports: clk, reset (sync, active-high), bus (valid/ready in and out).
module instruction_encoder #(
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  instruction_encoder_if.slave  bus
);

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] K_IMM   = 3'd0;
  localparam logic [2:0] K_LW    = 3'd1;
  localparam logic [2:0] K_S     = 3'd2;
  localparam logic [2:0] K_B     = 3'd3;
  localparam logic [2:0] K_J     = 3'd4;
  localparam logic [2:0] K_LUI   = 3'd5;
  localparam logic [2:0] K_AUIPC = 3'd6;
  localparam logic [2:0] K_LI    = 3'd7;

  typedef enum logic [1:0] {
    IDLE, ONE, HI, LO
  } state_e;

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [11:0] lo_q, lo_d;
  logic [4:0]  rd_q, rd_d;

  logic        accept;
  logic        load;
  logic        li_small;
  logic [19:0] li_hi;
  logic [32:0] enc_w;

  // {err, word} for every non-LI kind; err is the raw range verdict
  function automatic logic [32:0] enc(
    input logic [2:0]  kind,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [31:0] imm
  );
    logic [31:0] w;
    logic        bad;
    logic        s12;
    logic        s13;
    logic        s21;
    s12 = (&imm[31:11]) | ~(|imm[31:11]);
    s13 = (&imm[31:12]) | ~(|imm[31:12]);
    s21 = (&imm[31:20]) | ~(|imm[31:20]);
    w   = '0;
    bad = 1'b0;
    case (kind)
      K_IMM: begin
        w   = {imm[11:0], rs1, f3, rd, OP_IMM};
        bad = !s12;
      end
      K_LW: begin
        w   = {imm[11:0], rs1, f3, rd, OP_LOAD};
        bad = !s12;
      end
      K_S: begin
        w   = {imm[11:5], rs2, rs1, f3,
               imm[4:0], OP_STORE};
        bad = !s12;
      end
      K_B: begin
        w   = {imm[12], imm[10:5], rs2, rs1, f3,
               imm[4:1], imm[11], OP_BR};
        bad = !s13 | imm[0];
      end
      K_J: begin
        w   = {imm[20], imm[10:1], imm[11],
               imm[19:12], rd, OP_JAL};
        bad = !s21 | imm[0];
      end
      K_LUI: begin
        w   = {imm[31:12], rd, OP_LUI};
        bad = |imm[11:0];
      end
      K_AUIPC: begin
        w   = {imm[31:12], rd, OP_AUIPC};
        bad = |imm[11:0];
      end
      default: begin
        w   = '0;
        bad = 1'b0;
      end
    endcase
    return {bad, w};
  endfunction

  assign bus.in_ready = !reset &&
    ((state_q == IDLE) ||
     (valid_q && last_q && bus.out_ready));

  assign accept = bus.in_valid && bus.in_ready;

  assign li_small =
    (&bus.in_imm[31:11]) | ~(|bus.in_imm[31:11]);

  // ADDI sign-extends its 12 bits, so round the upper part up
  assign li_hi = bus.in_imm[31:12] +
                 {19'd0, bus.in_imm[11]};

  assign enc_w = enc(bus.in_kind, bus.in_rd,
                     bus.in_rs1, bus.in_rs2,
                     bus.in_funct3, bus.in_imm);

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    instr_d = instr_q;
    last_d  = last_q;
    err_d   = err_q;
    lo_d    = lo_q;
    rd_d    = rd_q;
    load    = 1'b0;

    unique case (state_q)
      IDLE: load = accept;
      HI: begin
        if (bus.out_ready) begin
          state_d = LO;
          instr_d = {lo_q, rd_q, 3'b000,
                     rd_q, OP_IMM};
          last_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      ONE, LO: begin
        if (bus.out_ready) begin
          if (accept) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
      end
    endcase

    if (load) begin
      valid_d = 1'b1;
      if (bus.in_kind == K_LI) begin
        err_d = 1'b0;
        if (li_small) begin
          state_d = ONE;
          last_d  = 1'b1;
          instr_d = {bus.in_imm[11:0], 5'd0,
                     3'b000, bus.in_rd, OP_IMM};
        end else begin
          // zero low part: the LUI alone is the final word
          instr_d = {li_hi, bus.in_rd, OP_LUI};
          lo_d    = bus.in_imm[11:0];
          rd_d    = bus.in_rd;
          if (bus.in_imm[11:0] == 12'd0) begin
            state_d = ONE;
            last_d  = 1'b1;
          end else begin
            state_d = HI;
            last_d  = 1'b0;
          end
        end
      end else begin
        state_d = ONE;
        last_d  = 1'b1;
        instr_d = enc_w[31:0];
        err_d   = enc_w[32] & CHECK_RANGE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      instr_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
      rd_q    <= rd_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_instr = instr_q;
  assign bus.out_last  = last_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder (range check on and off).
// Drives and samples #1 after each rising edge.
module tb_instruction_encoder;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  instruction_encoder_if bus ();
  instruction_encoder_if nc ();

  instruction_encoder #(.CHECK_RANGE(1'b1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  instruction_encoder #(.CHECK_RANGE(1'b0)) u_nc (
    .clk   (clk),
    .reset (reset),
    .bus   (nc)
  );

  assign nc.in_valid  = bus.in_valid;
  assign nc.in_kind   = bus.in_kind;
  assign nc.in_rd     = bus.in_rd;
  assign nc.in_rs1    = bus.in_rs1;
  assign nc.in_rs2    = bus.in_rs2;
  assign nc.in_funct3 = bus.in_funct3;
  assign nc.in_imm    = bus.in_imm;
  assign nc.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [2:0]  kind,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [31:0] imm
  );
    bus.in_valid  = 1'b1;
    bus.in_kind   = kind;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_imm    = imm;
  endtask

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{3'd0, 5'd5, 5'd0, 5'd0, 3'd0,
                 32'hFFFFFFFF, 32'hFFF00293, 1'b0};
    vecs[1]  = '{3'd2, 5'd0, 5'd2, 5'd6, 3'd2,
                 32'h8, 32'h00612423, 1'b0};
    vecs[2]  = '{3'd3, 5'd0, 5'd1, 5'd2, 3'd0,
                 32'h8, 32'h00208463, 1'b0};
    vecs[3]  = '{3'd4, 5'd1, 5'd0, 5'd0, 3'd0,
                 32'h800, 32'h001000EF, 1'b0};
    vecs[4]  = '{3'd3, 5'd0, 5'd0, 5'd0, 3'd0,
                 32'h3, 32'h00000163, 1'b1};
    vecs[5]  = '{3'd1, 5'd5, 5'd2, 5'd0, 3'd2,
                 32'h4, 32'h00412283, 1'b0};
    vecs[6]  = '{3'd0, 5'd1, 5'd0, 5'd0, 3'd0,
                 32'd2047, 32'h7FF00093, 1'b0};
    vecs[7]  = '{3'd0, 5'd1, 5'd0, 5'd0, 3'd0,
                 32'd2048, 32'h80000093, 1'b1};
    vecs[8]  = '{3'd4, 5'd0, 5'd0, 5'd0, 3'd0,
                 32'hFFFFE, 32'h7FFFF06F, 1'b0};
    vecs[9]  = '{3'd4, 5'd0, 5'd0, 5'd0, 3'd0,
                 32'h100000, 32'h8000006F, 1'b1};
    vecs[10] = '{3'd5, 5'd3, 5'd0, 5'd0, 3'd0,
                 32'h12345000, 32'h123451B7, 1'b0};
    vecs[11] = '{3'd6, 5'd3, 5'd0, 5'd0, 3'd0,
                 32'h1001, 32'h00001197, 1'b1};
    vecs[12] = '{3'd7, 5'd10, 5'd7, 5'd7, 3'd5,
                 32'hFFFFFFFF, 32'hFFF00513, 1'b0};
    vecs[13] = '{3'd7, 5'd3, 5'd0, 5'd0, 3'd0,
                 32'h12345000, 32'h123451B7, 1'b0};
    vecs[14] = '{3'd2, 5'd0, 5'd0, 5'd0, 3'd0,
                 32'hFFFFF7FF, 32'h7E000FA3, 1'b1};
  end

  task automatic single(input int i);
    string t;
    t = $sformatf("v%0d", i);
    bus.out_ready = 1'b0;
    drive(vecs[i].kind, vecs[i].rd, vecs[i].rs1,
          vecs[i].rs2, vecs[i].f3, vecs[i].imm);
    chk({t, "_rdy"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk({t, "_vld"}, 32'(bus.out_valid), 32'd1);
    chk({t, "_ins"}, bus.out_instr, vecs[i].exp);
    chk({t, "_lst"}, 32'(bus.out_last), 32'd1);
    chk({t, "_err"}, 32'(bus.out_err),
        32'(vecs[i].err));
    chk({t, "_ncins"}, nc.out_instr, vecs[i].exp);
    chk({t, "_ncerr"}, 32'(nc.out_err), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({t, "_idle"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic li2(
    input string       t,
    input logic [4:0]  rd,
    input logic [31:0] imm,
    input logic [31:0] exp_hi,
    input logic [31:0] exp_lo,
    input int          hold
  );
    bus.out_ready = 1'b0;
    drive(3'd7, rd, 5'd0, 5'd0, 3'd0, imm);
    tick();
    bus.in_valid = 1'b0;
    chk({t, "_hi"}, bus.out_instr, exp_hi);
    chk({t, "_hilst"}, 32'(bus.out_last), 32'd0);
    chk({t, "_hierr"}, 32'(bus.out_err), 32'd0);
    chk({t, "_hirdy"}, 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk({t, "_hold"}, bus.out_instr, exp_hi);
      chk({t, "_holdv"}, 32'(bus.out_valid), 32'd1);
      chk({t, "_holdr"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk({t, "_lo"}, bus.out_instr, exp_lo);
    chk({t, "_lolst"}, 32'(bus.out_last), 32'd1);
    chk({t, "_loerr"}, 32'(bus.out_err), 32'd0);
    chk({t, "_lordy"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.out_ready = 1'b0;
    chk({t, "_end"}, 32'(bus.out_valid), 32'd0);
  endtask

  logic [31:0] b2b_exp[3];

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.out_ready = 1'b0;
    drive(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    bus.in_valid = 1'b0;
    b2b_exp[0] = 32'h00100093;
    b2b_exp[1] = 32'h00200113;
    b2b_exp[2] = 32'h00300193;

    tick();
    tick();
    chk("rst_vld", 32'(bus.out_valid), 32'd0);
    chk("rst_ins", bus.out_instr, 32'd0);
    chk("rst_lst", 32'(bus.out_last), 32'd0);
    chk("rst_err", 32'(bus.out_err), 32'd0);
    chk("rst_rdy", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rdy", 32'(bus.in_ready), 32'd1);
    tick();

    for (int i = 0; i < 15; i++) single(i);

    li2("li3", 5'd10, 32'h12345FFF,
        32'h12346537, 32'hFFF50513, 3);
    li2("liwrap", 5'd1, 32'h7FFFF800,
        32'h800000B7, 32'h80008093, 0);

    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(3'd0, 5'(i + 1), 5'd0, 5'd0, 3'd0,
            32'(i + 1));
      chk($sformatf("b2b%0d_rdy", i),
          32'(bus.in_ready), 32'd1);
      tick();
      chk($sformatf("b2b%0d_vld", i),
          32'(bus.out_valid), 32'd1);
      chk($sformatf("b2b%0d_ins", i),
          bus.out_instr, b2b_exp[i]);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("b2b_end", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    drive(3'd7, 5'd10, 5'd0, 5'd0, 3'd0,
          32'h12345FFF);
    tick();
    bus.in_valid = 1'b0;
    chk("t6_hi", bus.out_instr, 32'h12346537);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_vld", 32'(bus.out_valid), 32'd0);
    #1;
    chk("t6_rdy", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_noaddi", 32'(bus.out_valid), 32'd0);
    end
    bus.out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
